// File: rtl/example_text_loader_if.sv
// example_text_loader_if: control, byte-stream, text-memory and status signals of the text loader
interface example_text_loader_if #(parameter int TEXT_BITS = 16);
  logic                 start;
  logic [TEXT_BITS-2:0] length;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 mem_wen;
  logic [TEXT_BITS-3:0] mem_waddr;
  logic [31:0]          mem_wdata;
  logic                 busy;
  logic                 done;
  logic                 cpu_hold;
  logic [31:0]          checksum;
  modport master (
    output start, length, in_valid, in_data,
    input  in_ready, mem_wen, mem_waddr, mem_wdata, busy, done, cpu_hold, checksum
  );
  modport slave (
    input  start, length, in_valid, in_data,
    output in_ready, mem_wen, mem_waddr, mem_wdata, busy, done, cpu_hold, checksum
  );
endinterface

// File: rtl/example_text_loader.sv
// example_text_loader: assembles a little-endian byte stream into 32-bit words and writes them to text memory
module example_text_loader #(
  parameter int TEXT_BITS = 16,
  parameter int WORDS     = 2**(TEXT_BITS-2)
) (
  input logic                  clock,
  input logic                  reset,
  example_text_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam logic [TEXT_BITS-2:0] CAP = (TEXT_BITS-1)'(WORDS);
  state_t               state_q, state_d;
  logic [TEXT_BITS-2:0] count_q, count_d, clamped;
  logic [TEXT_BITS-3:0] addr_q, addr_d;
  logic [1:0]           idx_q, idx_d;
  logic [31:0]          buf_q, buf_d, sum_q, sum_d;
  logic                 hold_q, hold_d;
  // Clamping the count keeps word_addr inside the memory, so no write ever wraps.
  always_comb begin
    clamped = bus.length > CAP ? CAP : bus.length;
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    sum_d   = sum_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (bus.start) begin
        count_d = clamped;
        addr_d  = '0;
        idx_d   = '0;
        sum_d   = '0;
        hold_d  = 1'b1;
        state_d = clamped != '0 ? RECV : DONE;
      end
      RECV: if (bus.in_valid) begin
        buf_d[{idx_q, 3'b000} +: 8] = bus.in_data;
        idx_d   = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? WRITE : RECV;
      end
      WRITE: begin
        sum_d   = sum_q + buf_q;
        addr_d  = addr_q + 1'b1;
        count_d = count_q - 1'b1;
        state_d = count_q == (TEXT_BITS-1)'(1) ? DONE : RECV;
      end
      DONE: begin
        hold_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      sum_q   <= '0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      sum_q   <= sum_d;
      hold_q  <= hold_d;
    end
  end
  assign bus.in_ready  = state_q == RECV;
  assign bus.mem_wen   = state_q == WRITE;
  assign bus.mem_waddr = addr_q;
  assign bus.mem_wdata = buf_q;
  assign bus.busy      = state_q == RECV || state_q == WRITE;
  assign bus.done      = state_q == DONE;
  assign bus.cpu_hold  = hold_q;
  assign bus.checksum  = sum_q;
endmodule

// File: tb/tb_example_text_loader.sv
// tb_example_text_loader: scoreboard bench; expected writes are queued at stimulus time and popped on mem_wen
module tb_example_text_loader;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  example_text_loader_if #(.TEXT_BITS(16)) bus();
  example_text_loader_if #(.TEXT_BITS(8))  bus_s();
  example_text_loader #(.TEXT_BITS(16)) dut   (.clock(clock), .reset(reset), .bus(bus.slave));
  example_text_loader #(.TEXT_BITS(8))  dut_s (.clock(clock), .reset(reset), .bus(bus_s.slave));
  typedef struct packed {logic [13:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  int passed = 0, total = 0, n_wr = 0, n_done = 0, s_wr = 0, s_done = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clock) begin
    if (bus.mem_wen) begin
      wr_t w;
      n_wr++;
      chk("write_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("waddr", 64'(bus.mem_waddr), 64'(w.a));
        chk("wdata", 64'(bus.mem_wdata), 64'(w.d));
      end
    end
    if (bus.done) n_done++;
    if (bus_s.mem_wen) begin
      chk("clamp_waddr", 64'(bus_s.mem_waddr), 64'(s_wr));
      s_wr++;
    end
    if (bus_s.done) begin
      chk("clamp_done_after_last", 64'(s_wr), 64'(64));
      s_done++;
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic start_load(input int len);
    bus.start  = 1'b1;
    bus.length = 15'(len);
    tick();
    bus.start  = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clock);
    while (!bus.in_ready && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (t >= 20) chk("in_ready_timeout", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int t = 0;
    @(negedge clock);
    while (!bus.done && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("done_seen", 64'(bus.done), 64'(1));
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int w0, d0, k, t;
    logic [6:0] pat;
    logic [7:0] bs [4];
    bus.start = 0; bus.length = '0; bus.in_valid = 0; bus.in_data = '0;
    bus_s.start = 0; bus_s.length = '0; bus_s.in_valid = 0; bus_s.in_data = '0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_mem_wen",  64'(bus.mem_wen),  64'(0));
    chk("rst_busy",     64'(bus.busy),     64'(0));
    chk("rst_done",     64'(bus.done),     64'(0));
    chk("rst_cpu_hold", 64'(bus.cpu_hold), 64'(1));
    chk("rst_checksum", 64'(bus.checksum), 64'(0));
    tick();
    // two-word load
    w0 = n_wr; d0 = n_done;
    exp_q.push_back('{14'h0, 32'h12345678});
    exp_q.push_back('{14'h1, 32'hDEADBEEF});
    start_load(2);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    @(negedge clock);
    chk("latency_wen", 64'(bus.mem_wen), 64'(1));
    chk("busy_write",  64'(bus.busy),    64'(1));
    tick();
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    wait_done();
    chk("hold_in_done", 64'(bus.cpu_hold), 64'(1));
    tick();
    @(negedge clock);
    chk("hold_after_done", 64'(bus.cpu_hold), 64'(0));
    chk("checksum_two",    64'(bus.checksum), 64'(32'hF0E21567));
    chk("writes_two",      64'(n_wr - w0),    64'(2));
    chk("done_pulses_two", 64'(n_done - d0),  64'(1));
    chk("queue_two",       64'(exp_q.size()), 64'(0));
    tick();
    // zero length
    w0 = n_wr;
    start_load(0);
    @(negedge clock);
    chk("zero_done", 64'(bus.done),    64'(1));
    chk("zero_busy", 64'(bus.busy),    64'(0));
    chk("zero_wen",  64'(bus.mem_wen), 64'(0));
    tick();
    @(negedge clock);
    chk("zero_done_end", 64'(bus.done),     64'(0));
    chk("zero_checksum", 64'(bus.checksum), 64'(0));
    chk("zero_hold",     64'(bus.cpu_hold), 64'(0));
    chk("zero_writes",   64'(n_wr - w0),    64'(0));
    tick();
    // stream gaps: in_valid sequence 1,0,0,1,1,0,1
    w0 = n_wr;
    exp_q.push_back('{14'h0, 32'hDDCCBBAA});
    bs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pat = 7'b1011001;
    k = 0;
    start_load(1);
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = pat[i];
      bus.in_data  = pat[i] ? bs[k] : 8'hFF;
      if (pat[i]) k++;
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("gap_wen", 64'(bus.mem_wen), 64'(1));
    wait_done();
    tick();
    chk("gap_writes", 64'(n_wr - w0),    64'(1));
    chk("gap_queue",  64'(exp_q.size()), 64'(0));
    // start while busy is ignored
    w0 = n_wr; d0 = n_done;
    exp_q.push_back('{14'h0, 32'h44332211});
    start_load(1);
    send(8'h11); send(8'h22);
    bus.start = 1'b1; bus.length = 15'd5;
    tick();
    bus.start = 1'b0;
    send(8'h33); send(8'h44);
    wait_done();
    repeat (10) tick();
    chk("ign_writes",   64'(n_wr - w0),     64'(1));
    chk("ign_done",     64'(n_done - d0),   64'(1));
    chk("ign_busy",     64'(bus.busy),      64'(0));
    chk("ign_checksum", 64'(bus.checksum),  64'(32'h44332211));
    chk("ign_queue",    64'(exp_q.size()),  64'(0));
    // clamp on a small instance: 100 requested, 64 fit
    bus_s.length = 7'd100;
    bus_s.start  = 1'b1;
    tick();
    bus_s.start    = 1'b0;
    bus_s.in_valid = 1'b1;
    bus_s.in_data  = 8'h01;
    t = 0;
    while (s_done == 0 && t < 2000) begin
      tick();
      t++;
    end
    bus_s.in_valid = 1'b0;
    chk("clamp_done",     64'(s_done),         64'(1));
    chk("clamp_writes",   64'(s_wr),           64'(64));
    chk("clamp_checksum", 64'(bus_s.checksum), 64'(32'h40404040));
    tick();
    // reset after two bytes of the second word
    w0 = n_wr;
    exp_q.push_back('{14'h0, 32'h0D0C0B0A});
    start_load(2);
    send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
    send(8'h01); send(8'h02);
    chk("pre_rst_checksum", 64'(bus.checksum), 64'(32'h0D0C0B0A));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_busy",     64'(bus.busy),     64'(0));
    chk("mid_rst_hold",     64'(bus.cpu_hold), 64'(1));
    chk("mid_rst_checksum", 64'(bus.checksum), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    repeat (10) tick();
    chk("mid_rst_writes", 64'(n_wr - w0),    64'(1));
    chk("mid_rst_queue",  64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/example_text_loader.md
EXAMPLE_TEXT_LOADER -- requirements
Module: example_text_loader

Interface
REQ-001 Parameter: WORDS, default 2**(rv_config::TEXT_BITS - 2), text memory capacity in 32-bit words.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-005 length  input  rv_config::TEXT_BITS-1  number of words to load; sampled with start.
REQ-006 in_valid  input  1  byte stream valid.
REQ-007 in_data  input  8  byte stream data, little-endian within each word.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_wen  output  1  text memory write strobe.
REQ-010 mem_waddr  output  rv_config::TEXT_BITS-2  text memory word address.
REQ-011 mem_wdata  output  32  text memory write data.
REQ-012 busy  output  1  a load is in progress (state RECV or WRITE).
REQ-013 done  output  1  one-cycle pulse at load completion.
REQ-014 cpu_hold  output  1  holds the core in reset while text memory is not valid.
REQ-015 checksum  output  32  mod-2^32 sum of all words written in the current or most recent load.

Function
REQ-016 The FSM SHALL have four states: IDLE, RECV, WRITE and DONE.
REQ-017 In IDLE, start=1 SHALL latch the word count and clear word_addr, byte_idx and checksum. The word count is min(length, WORDS).
REQ-018 From IDLE, start=1 SHALL go to RECV if the latched count is nonzero, else to DONE.
REQ-019 in_ready SHALL be 1 only in RECV; a byte is accepted when in_valid and in_ready are both 1.
REQ-020 Each accepted byte SHALL be placed in bits [8*byte_idx+7 : 8*byte_idx] of the word buffer, and byte_idx SHALL increment (2 bits, wrapping).
REQ-021 Acceptance with byte_idx=3 SHALL move RECV to WRITE; in_valid=0 SHALL leave RECV state and buffer unchanged.
REQ-022 In WRITE, for exactly one cycle: mem_wen=1, mem_waddr=word_addr, mem_wdata=buffer.
REQ-023 In that WRITE cycle: checksum += buffer; word_addr increments; remaining count decrements.
REQ-024 WRITE SHALL go to DONE when remaining count was 1, else to RECV.
REQ-025 Bytes-to-write latency: 4th byte accepted at cycle N implies mem_wen=1 at cycle N+1.
REQ-026 DONE SHALL last one cycle, with done=1 and cpu_hold cleared at its exit, then go to IDLE.
REQ-027 mem_wen SHALL be 0 outside WRITE; mem_waddr and mem_wdata are don't-care when mem_wen=0.
REQ-028 word_addr SHALL never exceed WORDS-1, because of the clamp in REQ-017; no wrap-around writes occur.
REQ-029 start SHALL be ignored in RECV, WRITE and DONE.
REQ-030 cpu_hold SHALL be set on reset and on an accepted start, and cleared only when leaving DONE.
REQ-031 busy SHALL be 1 exactly in RECV and WRITE.
REQ-032 checksum SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-033 reset=1 SHALL, on the next edge, force IDLE and apply these values: in_ready=0, mem_wen=0, busy=0, done=0, cpu_hold=1, checksum=0, word_addr=0, byte_idx=0, count=0.
REQ-034 reset SHALL take priority over every other input in the same cycle.
REQ-035 reset mid-load SHALL abandon the partial word with no further write; already written words are not undone.

Verification (TEXT_BITS=16: 14-bit address, 15-bit length, WORDS=16384)
REQ-036 Two-word load: start with length=2, bytes 78 56 34 12 EF BE AD DE, in_valid always 1 -> writes 0x12345678 @0 and 0xDEADBEEF @1; checksum=0xF0E21567; one done pulse; cpu_hold falls after DONE.
REQ-037 Zero length: start with length=0 -> DONE the next cycle, done=1 for one cycle, no mem_wen, checksum=0.
REQ-038 Stream gaps: one-word load, in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 bytes accepted, one write, data matches byte order.
REQ-039 Ignored start: start=1 pulsed while busy with length=5 during a length-1 load -> exactly one write; count unaffected.
REQ-040 Clamp: length=20000 -> word count 16384; the last write goes to address 0x3FFF, followed by done.
REQ-041 Reset mid-load: reset after 2 bytes of the second word -> no further mem_wen; state is IDLE, cpu_hold=1, checksum=0 on the following cycle.
